// File: rtl/xor4_parity_checker_if.sv
// Stream bundle around the parity checker.
// Upstream side: i_valid/o_ready handshake carrying i_data plus i_par.
// Downstream side: o_valid/i_ready handshake carrying o_data plus o_err.
// Signal names keep the checker's point of view (i_* into, o_* out of it).
// master: the environment (drives i_*, observes o_*).
// slave : the checker     (observes i_*, drives o_*).
interface xor4_parity_checker_if #(
  parameter int DATA_W = 4
);
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data;
  logic              i_par;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_err;

  modport master (
    output i_valid, i_data, i_par, i_ready,
    input  o_ready, o_valid, o_data, o_err
  );

  modport slave (
    input  i_valid, i_data, i_par, i_ready,
    output o_ready, o_valid, o_data, o_err
  );
endinterface

// File: rtl/xor4_parity_checker.sv
// Receive-side XOR parity checker.
// Recomputes parity of each accepted codeword, tags it with an error flag and
// buffers it in a 2-entry queue. A saturating counter tracks erroneous words.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   bus        : stream bundle (slave side), see xor4_parity_checker_if
//   i_clr_cnt  : synchronous clear of the error counter
//   o_err_cnt  : number of erroneous codewords accepted (saturating)
//   o_sat      : counter is at its maximum value
module xor4_parity_checker #(
  parameter int DATA_W = 4,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  xor4_parity_checker_if.slave bus,
  input  logic             i_clr_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_sat
);

  localparam bit             ODD_B   = (ODD != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  word_t  head, tail, in_word;
  logic   syn, ready, push, pop;
  logic [CNT_W-1:0] cnt_nxt;

  // Syndrome: 1 means the received word fails the parity check.
  assign syn     = (^bus.i_data) ^ bus.i_par ^ ODD_B;
  assign in_word = '{data: bus.i_data, err: syn};

  // Ready depends on occupancy only; reset gates it low combinationally.
  assign ready       = (state != FULL) & i_rst_n;
  assign bus.o_ready = ready;
  assign bus.o_valid = (state != EMPTY);
  assign bus.o_data  = head.data;
  assign bus.o_err   = head.err;

  assign push = bus.i_valid & ready;
  assign pop  = bus.o_valid & bus.i_ready;

  // Occupancy FSM. head always holds the oldest word, so outputs come
  // straight from a register and hold steady under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= in_word;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= in_word;        // new word replaces the departing head
          end else if (push) begin
            tail  <= in_word;
            state <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head  <= tail;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Clear applies before the increment, so clear + bad push yields 1.
  always_comb begin
    cnt_nxt = i_clr_cnt ? '0 : o_err_cnt;
    if (push && syn && (cnt_nxt != CNT_MAX))
      cnt_nxt = cnt_nxt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= '0;
      o_sat     <= 1'b0;
    end else begin
      o_err_cnt <= cnt_nxt;
      o_sat     <= (cnt_nxt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_xor4_parity_checker.sv
module tb_xor4_parity_checker;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr0 = 1'b0, clr1 = 1'b0;
  logic [1:0] cnt0;
  logic       sat0;
  logic [7:0] cnt1;
  logic       sat1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW:0] sb[$];   // {data, err}
  int          m_cnt;   // expected counter value of dut0 (CNT_W=2)

  always #5 clk = ~clk;

  xor4_parity_checker_if #(.DATA_W(DW)) bus0 ();
  xor4_parity_checker_if #(.DATA_W(DW)) bus1 ();

  // Even parity, 2-bit counter: main scoreboarded instance.
  xor4_parity_checker #(.DATA_W(DW), .ODD(0), .CNT_W(2)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus0),
    .i_clr_cnt(clr0), .o_err_cnt(cnt0), .o_sat(sat0)
  );

  // Odd parity instance for the ODD=1 case.
  xor4_parity_checker #(.DATA_W(DW), .ODD(1), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus1),
    .i_clr_cnt(clr1), .o_err_cnt(cnt1), .o_sat(sat1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Even-parity error: 1 when XOR of data and parity bit is 1.
  function automatic logic even_err(input logic [DW-1:0] d, input logic p);
    logic x = p;
    for (int i = 0; i < DW; i++) x = x ^ d[i];
    return x;
  endfunction

  // One cycle on dut0: drive, check against model, clock, update model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic p,
                      input logic rdy, input logic clr, input string tag);
    logic pu, po, e;
    bus0.i_valid = v; bus0.i_data = d; bus0.i_par = p;
    bus0.i_ready = rdy; clr0 = clr;
    #1;
    chk({tag, ".valid"}, 32'(bus0.o_valid), 32'(sb.size() > 0));
    chk({tag, ".ready"}, 32'(bus0.o_ready), 32'(sb.size() < 2));
    chk({tag, ".cnt"},   32'(cnt0), 32'(m_cnt));
    chk({tag, ".sat"},   32'(sat0), 32'(m_cnt == 3));
    if (sb.size() > 0) begin
      chk({tag, ".data"}, 32'(bus0.o_data), 32'(sb[0][DW:1]));
      chk({tag, ".err"},  32'(bus0.o_err),  32'(sb[0][0]));
    end
    @(posedge clk);
    e  = even_err(d, p);
    pu = v && (sb.size() < 2);
    po = rdy && (sb.size() > 0);
    if (clr) m_cnt = 0;
    if (pu && e && m_cnt < 3) m_cnt++;
    if (po) void'(sb.pop_front());
    if (pu) sb.push_back({d, e});
    @(negedge clk);
  endtask

  initial begin
    bus0.i_valid = 0; bus0.i_data = '0; bus0.i_par = 0; bus0.i_ready = 0;
    bus1.i_valid = 0; bus1.i_data = '0; bus1.i_par = 0; bus1.i_ready = 0;
    m_cnt = 0;

    // Reset state
    #12;
    chk("rst.valid", 32'(bus0.o_valid), 0);
    chk("rst.ready", 32'(bus0.o_ready), 0);
    chk("rst.data",  32'(bus0.o_data), 0);
    chk("rst.err",   32'(bus0.o_err), 0);
    chk("rst.cnt",   32'(cnt0), 0);
    chk("rst.sat",   32'(sat0), 0);
    rst_n = 1'b1;
    #1;
    chk("rel.ready", 32'(bus0.o_ready), 1);
    @(negedge clk);

    // Even-parity good word, then bad word
    step(1, 4'b1011, 1, 1, 0, "good");
    chk("good.direct.err", 32'(bus0.o_err), 0);
    chk("good.direct.data", 32'(bus0.o_data), 32'hB);
    step(1, 4'b1011, 0, 1, 0, "bad");
    chk("bad.direct.err", 32'(bus0.o_err), 1);
    chk("bad.direct.cnt", 32'(cnt0), 1);
    step(0, 4'h0, 0, 1, 0, "drain0");

    // Odd parity: 1011 with parity 0 is good
    bus1.i_valid = 1; bus1.i_data = 4'b1011; bus1.i_par = 0; bus1.i_ready = 0;
    @(posedge clk); #1;
    bus1.i_valid = 0;
    chk("odd.valid", 32'(bus1.o_valid), 1);
    chk("odd.data",  32'(bus1.o_data), 32'hB);
    chk("odd.err",   32'(bus1.o_err), 0);
    chk("odd.cnt",   32'(cnt1), 0);
    bus1.i_ready = 1;
    @(negedge clk);

    // Backpressure: 3rd word refused while FULL
    step(1, 4'h1, 1, 0, 0, "bp1");
    step(1, 4'h2, 1, 0, 0, "bp2");
    step(1, 4'h3, 0, 0, 0, "bp3");
    step(0, 4'h0, 0, 1, 0, "bp_pop1");
    step(0, 4'h0, 0, 1, 0, "bp_pop2");
    step(0, 4'h0, 0, 0, 0, "bp_empty");

    // Simultaneous push and pop in ONE
    step(1, 4'h5, 0, 0, 0, "pp_head");
    step(1, 4'hA, 0, 1, 0, "pp_both");
    step(0, 4'h0, 0, 1, 0, "pp_new");
    step(0, 4'h0, 0, 0, 0, "pp_empty");

    // Saturation (counter currently 1), then clear with a bad push
    for (int i = 0; i < 4; i++) step(1, 4'(i + 6), ~even_err(4'(i + 6), 0), 1, 0, "sat_push");
    step(0, 4'h0, 0, 1, 0, "sat_hold");
    chk("sat.direct.cnt", 32'(cnt0), 3);
    chk("sat.direct.sat", 32'(sat0), 1);
    step(1, 4'hC, 1, 1, 1, "clr_bad");
    step(0, 4'h0, 0, 1, 0, "clr_after");
    chk("clr.direct.cnt", 32'(cnt0), 1);
    chk("clr.direct.sat", 32'(sat0), 0);

    // Build FULL with count 2, then reset between edges
    step(0, 4'h0, 0, 1, 1, "pre_rst_clr");
    step(1, 4'h7, 0, 0, 0, "pre_rst1");
    step(1, 4'hE, 0, 0, 0, "pre_rst2");
    step(0, 4'h0, 0, 0, 0, "pre_rst_full");
    #1 rst_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(bus0.o_valid), 0);
    chk("mrst.ready", 32'(bus0.o_ready), 0);
    chk("mrst.cnt",   32'(cnt0), 0);
    chk("mrst.sat",   32'(sat0), 0);
    sb.delete();
    m_cnt = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("mrst.rel_ready", 32'(bus0.o_ready), 1);
    chk("mrst.rel_valid", 32'(bus0.o_valid), 0);
    @(negedge clk);
    step(1, 4'h9, 1, 0, 0, "post_rst");
    step(0, 4'h0, 0, 1, 0, "post_rst_out");
    step(0, 4'h0, 0, 0, 0, "post_rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xor4_parity_checker.md
Name: xor4_parity_checker

Overview:
- Receive-side counterpart of the 4-bit XOR parity generator.
- Accepts codewords (DATA_W data bits plus one parity bit) on a valid/ready input and recomputes the XOR parity.
- Buffers each word with a per-word error flag in a 2-entry output queue.
- Keeps a saturating count of parity errors for status readout.

Parameters:
- DATA_W, 4, data bits per codeword (must be >= 1).
- ODD, 0, 0 = even parity (XOR of data and parity bit = 0 is good); 1 = odd parity (XOR = 1 is good).
- CNT_W, 8, width of the error counter.

Ports:
- i_clk, input, 1, single clock; all state updates on the rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_valid, input, 1, input codeword present.
- o_ready, output, 1, block can accept a codeword this cycle.
- i_data, input, DATA_W, received data bits.
- i_par, input, 1, received parity bit.
- o_valid, output, 1, queue head is valid.
- i_ready, input, 1, downstream accepts the queue head.
- o_data, output, DATA_W, data bits of the queue head.
- o_err, output, 1, parity error flag of the queue head.
- i_clr_cnt, input, 1, synchronous clear of the error counter.
- o_err_cnt, output, CNT_W, number of erroneous codewords accepted.
- o_sat, output, 1, error counter is at its maximum value.

Behaviour:
- Reset: asynchronous, active-low; one clock, no other clock domains.
  - While i_rst_n = 0: queue emptied; o_valid = 0, o_data = 0, o_err = 0, o_err_cnt = 0, o_sat = 0.
  - o_ready is forced 0 while i_rst_n = 0 and returns to 1 combinationally on deassertion.
  - Reset mid-transfer discards all queued words and the count.
- Syndrome is combinational on the input: syn = XOR-reduce(i_data) ^ i_par ^ ODD. A word is erroneous when syn = 1.
- Push: occurs when i_valid & o_ready at a rising edge.
  - {i_data, syn} is written to the queue tail.
  - The input may change freely when no push occurs.
- Pop: occurs when o_valid & i_ready at a rising edge; the head is removed.
- Occupancy states:
  - EMPTY: o_valid = 0, o_ready = 1. Push -> ONE.
  - ONE: o_valid = 1, o_ready = 1.
    - Push only -> FULL.
    - Pop only -> EMPTY.
    - Push and pop together -> ONE; the new word becomes the head.
  - FULL: o_valid = 1, o_ready = 0, so push is impossible. Pop -> ONE.
- o_ready = (state != FULL) & i_rst_n. It depends only on state, never on i_ready (no combinational ready path).
- Latency: a word pushed at edge k is visible on o_data/o_err from edge k (next cycle) when the queue was EMPTY. There is no same-cycle input-to-output pass-through.
- Output stability: o_data and o_err are registered and hold while o_valid = 1 and i_ready = 0.
- Error counter:
  - Increments on a push with syn = 1, not on pop.
  - Saturates at 2^CNT_W - 1 and never wraps.
  - o_sat = (o_err_cnt == 2^CNT_W - 1), registered with the counter.
  - i_clr_cnt = 1 sets the counter to 0. If an erroneous push occurs in the same cycle, the counter becomes 1 (clear takes effect first, then the increment).
  - i_clr_cnt does not affect the queue.
- Undefined input bits are not required to be handled; the bench drives known values only.

Test Plan:
- Even-parity good word: ODD=0, push i_data=4'b1011, i_par=1 with i_ready=1.
  - Required: next cycle o_valid=1, o_data=4'b1011, o_err=0; o_err_cnt stays 0.
- Even-parity bad word: push i_data=4'b1011, i_par=0.
  - Required: o_err=1, o_err_cnt=1.
  - Repeat with ODD=1 and i_par=0: o_err=0.
- Backpressure: i_ready=0, present three words 4'h1, 4'h2, 4'h3 back-to-back.
  - Required: o_ready=0 after two pushes and 4'h3 is not accepted.
  - Then i_ready=1 for two cycles: outputs are 4'h1 then 4'h2; o_ready returns to 1 after the first pop.
- Simultaneous push and pop in ONE: head 4'h5, push 4'hA while popping.
  - Required: state remains ONE, o_data=4'hA next cycle, o_valid stays 1.
- Saturation and clear: CNT_W=2, push 4 bad words.
  - Required: o_err_cnt=3, o_sat=1.
  - Then i_clr_cnt=1 together with a bad push: o_err_cnt=1, o_sat=0.
- Reset mid-operation: queue FULL and o_err_cnt=2, then pulse i_rst_n low between clock edges.
  - Required: immediately o_valid=0, o_ready=0, o_err_cnt=0.
  - After release: o_ready=1 and the first new push is output correctly.
